// File: rtl/inpdt_pkg.sv
// ============================================================================
// Module      : inpdt_pkg
// Description : Shared widths, FSM state type and saturation bounds for the
//               inner-product accumulator and requantiser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inpdt_pkg;

  localparam int PSUM_W  = 21;
  localparam int DATA_W  = 9;
  localparam int SAT_MAX = 255;
  localparam int SAT_MIN = -256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/inpdt_requant.sv
// ============================================================================
// Module      : inpdt_requant
// Description : Combinational floor shift of a signed accumulator followed by
//               saturation to 9-bit signed, with a clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inpdt_requant
  import inpdt_pkg::*;
#(
  parameter int ACC_W     = 28,
  parameter int OUT_SHIFT = 7
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] result_o,
  output logic              sat_o
);

  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] w_shifted;

  // Arithmetic shift of a signed value is a floor division (rounds to -inf).
  assign w_shifted = $signed(acc_i) >>> OUT_SHIFT;

  always_comb begin
    result_o = w_shifted[DATA_W-1:0];
    sat_o    = 1'b0;
    if (w_shifted > C_MAX) begin
      result_o = C_MAX[DATA_W-1:0];
      sat_o    = 1'b1;
    end else if (w_shifted < C_MIN) begin
      result_o = C_MIN[DATA_W-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inpdt_acc.sv
// ============================================================================
// Module      : inpdt_acc
// Description : Accumulates NUM_CHUNK partial sums plus a scaled bias into a
//               dot product, requantises it and presents it over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inpdt_acc
  import inpdt_pkg::*;
#(
  parameter int NUM_CHUNK  = 4,
  parameter int ACC_W      = 28,
  parameter int BIAS_SHIFT = 7,
  parameter int OUT_SHIFT  = 7
) (
  input  logic              iClk,
  input  logic              iRstn,
  input  logic              iValid,
  input  logic [PSUM_W-1:0] iPsum,
  input  logic [DATA_W-1:0] iBias,
  input  logic              iClear,
  output logic              oReady,
  output logic              oInpdtEn,
  input  logic              iReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oResult,
  output logic [ACC_W-1:0]  oAcc,
  output logic              oSat
);

  localparam int               CNT_W    = $clog2(NUM_CHUNK + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNK - 1);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               last_chunk;
  logic [ACC_W-1:0]   psum_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [DATA_W-1:0]  rq_result;
  logic               rq_sat;

  assign oReady   = (state_q != OUT) & ~iClear;
  assign accept   = iValid & oReady;
  assign oInpdtEn = accept;

  assign psum_ext = {{(ACC_W-PSUM_W){iPsum[PSUM_W-1]}}, iPsum};
  assign bias_ext = {{(ACC_W-DATA_W){iBias[DATA_W-1]}}, iBias} << BIAS_SHIFT;

  // The first chunk of a vector restarts the sum with the bias folded in.
  always_comb begin
    acc_d      = (state_q == IDLE) ? (psum_ext + bias_ext) : (acc_q + psum_ext);
    last_chunk = (state_q == IDLE) ? (NUM_CHUNK == 1) : (cnt_q == LAST_CNT);
  end

  inpdt_requant #(
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_requant (
    .acc_i    (acc_d),
    .result_o (rq_result),
    .sat_o    (rq_sat)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      oValid  <= 1'b0;
      oResult <= '0;
      oAcc    <= '0;
      oSat    <= 1'b0;
    end else if (iClear) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      oValid  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= (state_q == IDLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
            if (last_chunk) begin
              state_q <= OUT;
              oValid  <= 1'b1;
              oAcc    <= acc_d;
              oResult <= rq_result;
              oSat    <= rq_sat;
            end else begin
              state_q <= ACC;
            end
          end
        end
        OUT: begin
          if (iReady) begin
            state_q <= IDLE;
            oValid  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inpdt_acc.sv
// ============================================================================
// Module      : tb_inpdt_acc
// Description : Scoreboard bench for inpdt_acc (NUM_CHUNK=4 and NUM_CHUNK=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inpdt_acc;

  localparam int NC    = 4;
  localparam int ACC_W = 28;
  localparam int BS    = 7;
  localparam int OS    = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             iRstn, iValid, iClear, iReady;
  logic [20:0]      iPsum;
  logic [8:0]       iBias;
  logic             oReady, oInpdtEn, oValid, oSat;
  logic [8:0]       oResult;
  logic [ACC_W-1:0] oAcc;

  logic             iValid1;
  logic             oReady1, oInpdtEn1, oValid1, oSat1;
  logic [8:0]       oResult1;
  logic [ACC_W-1:0] oAcc1;

  inpdt_acc #(.NUM_CHUNK(NC), .ACC_W(ACC_W), .BIAS_SHIFT(BS), .OUT_SHIFT(OS)) dut (
    .iClk(clk), .iRstn(iRstn), .iValid(iValid), .iPsum(iPsum), .iBias(iBias),
    .iClear(iClear), .oReady(oReady), .oInpdtEn(oInpdtEn), .iReady(iReady),
    .oValid(oValid), .oResult(oResult), .oAcc(oAcc), .oSat(oSat)
  );

  inpdt_acc #(.NUM_CHUNK(1), .ACC_W(ACC_W), .BIAS_SHIFT(BS), .OUT_SHIFT(OS)) dut1 (
    .iClk(clk), .iRstn(iRstn), .iValid(iValid1), .iPsum(21'd12800), .iBias(9'd1),
    .iClear(1'b0), .oReady(oReady1), .oInpdtEn(oInpdtEn1), .iReady(1'b1),
    .oValid(oValid1), .oResult(oResult1), .oAcc(oAcc1), .oSat(oSat1)
  );

  typedef struct {
    longint acc;
    longint res;
    bit     sat;
  } exp_t;

  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  bit     exp_out = 1'b0;
  bit     acc_now = 1'b0;
  bit     mon_en  = 1'b0;
  bit     want_rdy;
  bit     rdy_rand = 1'b0;
  int     rdy_lo = 0;
  longint last_res = 0;
  longint vp[NC];
  longint vb;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer dot product, floor division, clip to 9-bit signed.
  function automatic exp_t model(input longint sum);
    exp_t   m;
    longint d;
    longint r;
    d = longint'(1) << OS;
    r = sum / d;
    if (sum < 0 && (sum % d) != 0) r = r - 1;
    m.acc = sum;
    m.sat = (r > 255) || (r < -256);
    m.res = (r > 255) ? 255 : ((r < -256) ? -256 : r);
    return m;
  endfunction

  always @(posedge clk) begin
    #2;
    if (rdy_lo > 0) begin
      iReady = 1'b0;
      rdy_lo--;
    end else begin
      iReady = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Monitor: handshake/flow checks every cycle, data against scoreboard head.
  always @(negedge clk) begin
    if (mon_en && iRstn) begin
      want_rdy = !exp_out && !iClear;
      check("oValid", oValid, exp_out);
      check("oReady", oReady, want_rdy);
      check("oInpdtEn", oInpdtEn, iValid && want_rdy);
      acc_now = iValid && want_rdy;
      if (oValid && exp_out) begin
        if (q.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          check("oAcc", $signed(oAcc), q[0].acc);
          check("oResult", $signed(oResult), q[0].res);
          check("oSat", oSat, q[0].sat);
          if (iReady) begin
            last_res = q[0].res;
            void'(q.pop_front());
            exp_out = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input longint p, input longint b);
    int n;
    n = 0;
    iValid = 1'b1;
    iPsum  = 21'(p);
    iBias  = 9'(b);
    do begin
      @(negedge clk); #1;
      n++;
    end while (!acc_now && n < 200);
    if (!acc_now) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic run_vec(input int gmin, input int gmax, input int hold);
    longint sum;
    sum = vb * (longint'(1) << BS);
    for (int i = 0; i < NC; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        @(posedge clk); #1;
      end
      if (i == NC - 1 && hold > 0) rdy_lo = hold + 1;
      send(vp[i], (i == 0) ? vb : longint'($urandom_range(511, 0)));
      sum += vp[i];
    end
    q.push_back(model(sum));
    exp_out = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input longint a, input longint b, input longint c,
                         input longint d, input longint bias);
    vp[0] = a; vp[1] = b; vp[2] = c; vp[3] = d; vb = bias;
  endtask

  initial begin
    exp_t e;
    iRstn = 1'b0; iValid = 1'b0; iClear = 1'b0; iReady = 1'b1;
    iPsum = '0; iBias = '0; iValid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oValid", oValid, 0);
    check("rst_oResult", oResult, 0);
    check("rst_oAcc", oAcc, 0);
    check("rst_oSat", oSat, 0);
    iRstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    set_vec(1000, 2000, -500, 300, 3);          run_vec(0, 0, 0); drain();
    set_vec(1048575, 1048575, 1048575, 1048575, 0); run_vec(0, 0, 0); drain();
    set_vec(-1048576, -1048576, -1048576, -1048576, 0); run_vec(0, 0, 0); drain();
    set_vec(-1, 0, 0, 0, 0);                    run_vec(0, 0, 0); drain();
    set_vec(127, 0, 0, 0, 0);                   run_vec(0, 0, 0); drain();
    // Gapped input and three cycles of output backpressure.
    set_vec(1000, 2000, -500, 300, 3);          run_vec(2, 2, 3); drain();

    // Asynchronous reset in the middle of a vector.
    send(10, 5);
    send(20, 0);
    #2 iRstn = 1'b0;
    #1;
    check("arst_oValid", oValid, 0);
    check("arst_oResult", oResult, 0);
    check("arst_oAcc", oAcc, 0);
    check("arst_oSat", oSat, 0);
    exp_out = 1'b0;
    @(posedge clk); #1;
    iRstn = 1'b1;
    set_vec(10, 20, 30, 40, 0); run_vec(0, 0, 0); drain();

    // Synchronous clear in the middle of a vector keeps the output data.
    set_vec(1000, 2000, -500, 300, 3); run_vec(0, 0, 0); drain();
    send(10, 5);
    send(20, 0);
    iClear = 1'b1;
    @(posedge clk); #1;
    iClear = 1'b0;
    check("clr_oValid", oValid, 0);
    check("clr_oResult_kept", $signed(oResult), last_res);
    set_vec(10, 20, 30, 40, 0); run_vec(0, 0, 0); drain();

    // Clear while a result waits for the consumer.
    set_vec(-7000, 300000, 12, -5, -100); run_vec(0, 0, 1000);
    @(posedge clk); #1;
    iClear = 1'b1;
    @(posedge clk); #1;
    iClear = 1'b0;
    exp_out = 1'b0;
    e = q.pop_front();
    rdy_lo = 0;
    check("clrout_oValid", oValid, 0);
    check("clrout_oResult", $signed(oResult), e.res);
    check("clrout_oAcc", $signed(oAcc), e.acc);
    @(posedge clk); #1;

    // Randomised vectors with random gaps and random consumer stalls.
    rdy_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < NC; i++) begin
        if (v % 2 == 0) vp[i] = longint'($signed(21'($urandom)));
        else            vp[i] = longint'($urandom_range(40000, 0)) - 20000;
      end
      vb = longint'($signed(9'($urandom)));
      run_vec(0, 2, 0);
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk); #1;

    // NUM_CHUNK=1 build: one vector every two cycles under constant input.
    e = model(12800 + (longint'(1) << BS));
    iValid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("n1_oValid", oValid1, i % 2);
      check("n1_oInpdtEn", oInpdtEn1, (i % 2) == 0);
      if (i % 2 == 1) begin
        check("n1_oAcc", $signed(oAcc1), e.acc);
        check("n1_oResult", $signed(oResult1), e.res);
        check("n1_oSat", oSat1, e.sat);
      end
    end
    @(posedge clk); #1;
    iValid1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
